// File: rtl/snn_infer_ctrl.sv
// APB-controlled inference sequencer for a spiking network: pixel buffer, timestep run, spike counting, winner scan.
// Optional feature macro SNN_CTRL_IRQ_EN adds the irq output and CTRL[1] irq_en.
module snn_infer_ctrl #(
    parameter int INPUT_SIZE    = 784,
    parameter int OUTPUT_SIZE   = 10,
    parameter int PIXEL_WIDTH   = 8,
    parameter int NUM_STEPS_DEF = 100
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [15:0]                       paddr,
    input  logic                              psel,
    input  logic                              penable,
    input  logic                              pwrite,
    input  logic [31:0]                       pwdata,
    output logic [31:0]                       prdata,
    output logic                              pready,
    output logic [INPUT_SIZE*PIXEL_WIDTH-1:0] pixel_input,
    output logic [7:0]                        leak_factor,
    output logic                              snn_clear,
    output logic                              snn_valid,
`ifdef SNN_CTRL_IRQ_EN
    output logic                              irq,
`endif
    input  logic [OUTPUT_SIZE-1:0]            digit_spikes
);
    localparam int PIX_AW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int CNT_AW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, SCAN, DONE} state_t;

    state_t                         state_reg, state_next;
    logic [PIXEL_WIDTH-1:0]         pixel_reg [INPUT_SIZE];
    logic [OUTPUT_SIZE-1:0][15:0]   count_reg;
    logic [7:0]                     leak_reg;
    logic [15:0]                    steps_reg;
    logic [15:0]                    step_cnt_reg;
    logic [CNT_AW-1:0]              scan_idx_reg;
    logic [CNT_AW-1:0]              best_idx_reg;
    logic [15:0]                    best_cnt_reg;
    logic [CNT_AW-1:0]              result_win_reg;
    logic [15:0]                    result_cnt_reg;
    logic                           done_reg;
    logic                           err_reg;
    logic                           irq_en_reg;
    logic [31:0]                    prdata_reg;
    logic [31:0]                    rd_data;

    logic [13:0] word_addr, cnt_off, pix_off;
    logic        wr_en, rd_setup, busy;
    logic        is_ctrl, is_status, is_leak, is_steps, is_result, cnt_hit, pix_hit;
    logic        start_req, err_set, status_w1c_done, status_w1c_err;
    logic        unused_bits;

    assign word_addr = paddr[15:2];
    assign cnt_off   = word_addr - 14'h040;
    assign pix_off   = word_addr - 14'h400;
    assign is_ctrl   = (word_addr == 14'h000);
    assign is_status = (word_addr == 14'h001);
    assign is_leak   = (word_addr == 14'h002);
    assign is_steps  = (word_addr == 14'h003);
    assign is_result = (word_addr == 14'h004);
    assign cnt_hit   = (word_addr >= 14'h040) && (cnt_off < 14'(OUTPUT_SIZE));
    assign pix_hit   = (word_addr >= 14'h400) && (pix_off < 14'(INPUT_SIZE));

    assign wr_en     = psel & penable & pwrite;
    assign rd_setup  = psel & ~penable & ~pwrite;
    assign busy      = (state_reg != IDLE);
    assign start_req = wr_en & is_ctrl & pwdata[0] & ~busy;
    assign err_set   = wr_en & busy & ((is_ctrl & pwdata[0]) | is_leak | is_steps | pix_hit);
    assign status_w1c_done = wr_en & is_status & pwdata[1];
    assign status_w1c_err  = wr_en & is_status & pwdata[2];
    assign unused_bits = &{1'b0, pwdata[31:16], paddr[1:0]};

    assign pready      = 1'b1;
    assign prdata      = prdata_reg;
    assign leak_factor = leak_reg;
`ifdef SNN_CTRL_IRQ_EN
    assign irq = done_reg & irq_en_reg;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < INPUT_SIZE; gi++) begin : g_pix_out
            assign pixel_input[gi*PIXEL_WIDTH +: PIXEL_WIDTH] = pixel_reg[gi];
        end
    endgenerate

    // Read data is captured in the setup phase so it is stable throughout the access phase.
    always_comb begin
        rd_data = '0;
        if (is_ctrl) begin
`ifdef SNN_CTRL_IRQ_EN
            rd_data = {30'd0, irq_en_reg, 1'b0};
`endif
        end else if (is_status) begin
            rd_data = {29'd0, err_reg, done_reg, busy};
        end else if (is_leak) begin
            rd_data = {24'd0, leak_reg};
        end else if (is_steps) begin
            rd_data = {16'd0, steps_reg};
        end else if (is_result) begin
            rd_data = {result_cnt_reg, {(16-CNT_AW){1'b0}}, result_win_reg};
        end else if (cnt_hit) begin
            rd_data = {16'd0, count_reg[cnt_off[CNT_AW-1:0]]};
        end else if (pix_hit) begin
            rd_data = 32'(pixel_reg[pix_off[PIX_AW-1:0]]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        snn_clear  = 1'b0;
        snn_valid  = 1'b0;
        case (state_reg)
            IDLE:  if (start_req) state_next = CLEAR;
            CLEAR: begin
                snn_clear  = 1'b1;
                state_next = (steps_reg == 16'd0) ? SCAN : RUN;
            end
            RUN: begin
                snn_valid = 1'b1;
                if (step_cnt_reg == 16'd1) state_next = SCAN;
            end
            SCAN:  if (scan_idx_reg == CNT_AW'(OUTPUT_SIZE-1)) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < INPUT_SIZE; i++) pixel_reg[i] <= '0;
            leak_reg       <= 8'h10;
            steps_reg      <= 16'(NUM_STEPS_DEF);
            irq_en_reg     <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            prdata_reg     <= '0;
            step_cnt_reg   <= '0;
            scan_idx_reg   <= '0;
            best_idx_reg   <= '0;
            best_cnt_reg   <= '0;
            result_win_reg <= '0;
            result_cnt_reg <= '0;
        end else begin
            if (wr_en && !busy) begin
                if (is_leak)  leak_reg  <= pwdata[7:0];
                if (is_steps) steps_reg <= pwdata[15:0];
                if (pix_hit)  pixel_reg[pix_off[PIX_AW-1:0]] <= pwdata[PIXEL_WIDTH-1:0];
            end
`ifdef SNN_CTRL_IRQ_EN
            if (wr_en && is_ctrl) irq_en_reg <= pwdata[1];
`endif
            // Set events take priority over a coincident write-one-to-clear.
            if (state_reg == DONE)   done_reg <= 1'b1;
            else if (status_w1c_done) done_reg <= 1'b0;
            if (err_set)             err_reg <= 1'b1;
            else if (status_w1c_err) err_reg <= 1'b0;
            if (rd_setup) prdata_reg <= rd_data;

            case (state_reg)
                CLEAR: begin
                    step_cnt_reg <= steps_reg;
                    scan_idx_reg <= '0;
                    best_idx_reg <= '0;
                    best_cnt_reg <= '0;
                end
                RUN: step_cnt_reg <= step_cnt_reg - 16'd1;
                SCAN: begin
                    // Strictly-greater keeps the lowest index on ties.
                    if (count_reg[scan_idx_reg] > best_cnt_reg) begin
                        best_cnt_reg <= count_reg[scan_idx_reg];
                        best_idx_reg <= scan_idx_reg;
                    end
                    scan_idx_reg <= scan_idx_reg + 1'b1;
                end
                DONE: begin
                    result_win_reg <= best_idx_reg;
                    result_cnt_reg <= best_cnt_reg;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            for (int k = 0; k < OUTPUT_SIZE; k++) begin
                if (state_reg == CLEAR)
                    count_reg[k] <= '0;
                else if (state_reg == RUN && digit_spikes[k] && count_reg[k] != 16'hFFFF)
                    count_reg[k] <= count_reg[k] + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_snn_infer_ctrl.sv
// Directed testbench for snn_infer_ctrl: register access, inference runs, tie rule, saturation, busy errors, reset abort.
module tb_snn_infer_ctrl;
    localparam int IN_SZ  = 784;
    localparam int OUT_SZ = 10;
    localparam int PW     = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [15:0]       paddr = '0;
    logic              psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0]       pwdata = '0;
    logic [31:0]       prdata;
    logic              pready;
    logic [IN_SZ*PW-1:0] pixel_input;
    logic [7:0]        leak_factor;
    logic              snn_clear, snn_valid;
    logic [OUT_SZ-1:0] digit_spikes = '0;
`ifdef SNN_CTRL_IRQ_EN
    logic              irq;
`endif

    int n_checks = 0;
    int n_errors = 0;

    snn_infer_ctrl #(
        .INPUT_SIZE(IN_SZ), .OUTPUT_SIZE(OUT_SZ), .PIXEL_WIDTH(PW), .NUM_STEPS_DEF(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pixel_input(pixel_input), .leak_factor(leak_factor),
        .snn_clear(snn_clear), .snn_valid(snn_valid),
`ifdef SNN_CTRL_IRQ_EN
        .irq(irq),
`endif
        .digit_spikes(digit_spikes)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [15:0] addr, input logic [31:0] data);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        $display("%0t APB WR addr=0x%04h data=0x%08h", $time, addr, data);
    endtask

    task automatic apb_read(input logic [15:0] addr, output logic [31:0] data);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        @(negedge clk);
        penable = 1'b1;
        data = prdata;
        check_eq("pready", {31'd0, pready}, 32'd1);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        $display("%0t APB RD addr=0x%04h data=0x%08h", $time, addr, data);
    endtask

    task automatic read_check(input string tag, input logic [15:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(addr, d);
        check_eq(tag, d, exp);
    endtask

    // Starts a run and counts cycles from the committing edge until done is raised.
    task automatic start_and_time(input int budget, output int lat, output int clr_cnt, output int val_cnt);
        lat = 0; clr_cnt = 0; val_cnt = 0;
        apb_write(16'h0000, 32'h1);
        for (int c = 1; c <= budget; c++) begin
            clr_cnt += int'(snn_clear);
            val_cnt += int'(snn_valid);
            @(posedge clk); #1;
            if (dut.done_reg) begin
                lat = c;
                break;
            end
        end
        $display("%0t RUN latency=%0d clear=%0d valid=%0d", $time, lat, clr_cnt, val_cnt);
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(posedge clk); #1;
            seen = dut.done_reg;
        end
        check_eq("done_within_budget", {31'd0, seen}, 32'd1);
    endtask

    logic [OUT_SZ-1:0][15:0] sat_preload;
    int lat, clr_cnt, val_cnt;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_leak", {24'd0, leak_factor}, 32'h10);
        check_eq("rst_clear", {31'd0, snn_clear}, 32'd0);
        check_eq("rst_valid", {31'd0, snn_valid}, 32'd0);
        check_eq("rst_prdata", prdata, 32'd0);
        check_eq("rst_pix0", {24'd0, pixel_input[7:0]}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        read_check("rst_steps", 16'h000C, 32'd100);
        read_check("rst_status", 16'h0004, 32'd0);
        read_check("rst_result", 16'h0010, 32'd0);

        // Register access and pixel buffer
        apb_write(16'h1000, 32'hAB);
        apb_write(16'h0008, 32'h20);
        apb_write(16'h1C3C, 32'h5A);
        check_eq("pix0_out", {24'd0, pixel_input[7:0]}, 32'hAB);
        check_eq("pix783_out", {24'd0, pixel_input[783*8 +: 8]}, 32'h5A);
        check_eq("leak_out", {24'd0, leak_factor}, 32'h20);
        read_check("pix0_rd", 16'h1000, 32'hAB);
        read_check("leak_rd", 16'h0008, 32'h20);
        read_check("pix783_rd", 16'h1C3C, 32'h5A);
        apb_write(16'h0024, 32'hFFFF_FFFF);
        read_check("unmapped_rd", 16'h0024, 32'd0);
        read_check("past_pix_rd", 16'h1C40, 32'd0);
        read_check("ctrl_rd", 16'h0000, 32'd0);

        // Single winner, 5 steps
        apb_write(16'h000C, 32'd5);
        digit_spikes = 10'b00_0000_1000;
        start_and_time(100, lat, clr_cnt, val_cnt);
        check_eq("lat_s5", 32'(lat), 32'd17);
        check_eq("clear_cycles", 32'(clr_cnt), 32'd1);
        check_eq("valid_cycles_s5", 32'(val_cnt), 32'd5);
        read_check("count3_s5", 16'h010C, 32'd5);
        read_check("count2_s5", 16'h0108, 32'd0);
        read_check("result_s5", 16'h0010, 32'h0005_0003);
        read_check("status_done", 16'h0004, 32'b010);
        apb_write(16'h0004, 32'b010);
        read_check("status_w1c", 16'h0004, 32'd0);

        // Tie between digits 2 and 7
        apb_write(16'h000C, 32'd4);
        digit_spikes = 10'b00_1000_0100;
        start_and_time(100, lat, clr_cnt, val_cnt);
        check_eq("lat_s4", 32'(lat), 32'd16);
        read_check("count7_s4", 16'h011C, 32'd4);
        read_check("result_tie", 16'h0010, 32'h0004_0002);
        apb_write(16'h0004, 32'b010);

        // Zero steps, no spikes
        apb_write(16'h000C, 32'd0);
        digit_spikes = '0;
        start_and_time(100, lat, clr_cnt, val_cnt);
        check_eq("lat_s0", 32'(lat), 32'd12);
        check_eq("valid_cycles_s0", 32'(val_cnt), 32'd0);
        read_check("result_zero", 16'h0010, 32'd0);
        apb_write(16'h0004, 32'b010);

        // Writes while busy during RUN
        apb_write(16'h000C, 32'd20);
        apb_write(16'h0000, 32'h1);
        apb_write(16'h0000, 32'h1);
        read_check("err_start_busy", 16'h0004, 32'b101);
        apb_write(16'h0004, 32'b100);
        read_check("err_w1c", 16'h0004, 32'b001);
        apb_write(16'h0008, 32'h77);
        read_check("err_leak_busy", 16'h0004, 32'b101);
        check_eq("leak_kept", {24'd0, leak_factor}, 32'h20);
        wait_done(100);
        read_check("status_done_err", 16'h0004, 32'b110);
        apb_write(16'h0004, 32'b110);

        // Pixel write during SCAN
        apb_write(16'h000C, 32'd0);
        apb_write(16'h0000, 32'h1);
        apb_write(16'h1000, 32'h11);
        check_eq("pix_kept", {24'd0, pixel_input[7:0]}, 32'hAB);
        wait_done(100);
        read_check("err_pix_scan", 16'h0004, 32'b110);
        apb_write(16'h0004, 32'b110);
        read_check("status_clean", 16'h0004, 32'd0);

        // Saturation with a forced counter preload
        apb_write(16'h000C, 32'h0FFF);
        digit_spikes = 10'b00_0000_0001;
        apb_write(16'h0000, 32'h1);
        repeat (10) @(posedge clk);
        sat_preload = '0;
        sat_preload[0] = 16'hFFF0;
        @(negedge clk);
        force dut.count_reg = sat_preload;
        @(negedge clk);
        release dut.count_reg;
        wait_done(5000);
        read_check("count0_sat", 16'h0100, 32'h0000_FFFF);
        read_check("count1_sat", 16'h0104, 32'd0);
        read_check("result_sat", 16'h0010, 32'hFFFF_0000);
        apb_write(16'h0004, 32'b010);

        // Reset mid-RUN
        apb_write(16'h000C, 32'd50);
        apb_write(16'h0000, 32'h1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("valid_before_rst", {31'd0, snn_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("valid_in_rst", {31'd0, snn_valid}, 32'd0);
        check_eq("clear_in_rst", {31'd0, snn_clear}, 32'd0);
        check_eq("leak_in_rst", {24'd0, leak_factor}, 32'h10);
        check_eq("pix_in_rst", {24'd0, pixel_input[7:0]}, 32'd0);
        check_eq("prdata_in_rst", prdata, 32'd0);
`ifdef SNN_CTRL_IRQ_EN
        check_eq("irq_in_rst", {31'd0, irq}, 32'd0);
`endif
        @(negedge clk); rst_n = 1'b1;
        read_check("status_after_rst", 16'h0004, 32'd0);
        repeat (80) @(posedge clk);
        read_check("status_no_done", 16'h0004, 32'd0);
        read_check("result_after_rst", 16'h0010, 32'd0);
        read_check("steps_after_rst", 16'h000C, 32'd100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
